// File: rtl/sift_out_pkg.sv
// Shared definitions for the sift-out adder controller: state encoding,
// default widths/latency and the wait-counter load helper.
package sift_out_pkg;

    localparam int unsigned DEF_ADDER_WIDTH = 32;
    localparam int unsigned DEF_LAT         = 2;
    localparam int unsigned DEF_CNT_W       = 16;
    // Wide enough for the largest legal LAT-1 (14).
    localparam int unsigned LAT_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

    // Value loaded into the settle counter at accept; the counter's done flag
    // is registered, so loading LAT-1 yields capture LAT+1 edges after accept.
    function automatic logic [LAT_CNT_W-1:0] lat_load_val(input int unsigned lat);
        int unsigned v;
        v = lat - 32'd1;
        return v[LAT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sift_out_lat_cnt.sv
// Loadable down-counter with a registered done flag. done_o rises on the
// edge after the count has reached zero while enabled and stays high until
// the next load.
module sift_out_lat_cnt
    import sift_out_pkg::*;
#(
    parameter int unsigned W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    // Next-state: load has priority, otherwise count down while enabled.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            done_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q != {W{1'b0}}) begin
                cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            done_d = (cnt_q == {W{1'b0}});
        end else begin
            cnt_d  = cnt_q;
            done_d = done_q;
        end
    end

    // Counter and done flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {W{1'b0}};
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/sift_out_adder_ctrl.sv
// Initiator-side sequencer for the sift-out fault-tolerant adder. Issues one
// operation at a time, waits the adder settle latency, returns the result and
// owns the K discipline (K=1 on the first issue after reset or reinit).
module sift_out_adder_ctrl
    import sift_out_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int unsigned LAT         = DEF_LAT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDER_WIDTH-1:0] req_a,
    input  logic [ADDER_WIDTH-1:0] req_b,
    input  logic                   req_cin,
    input  logic                   reinit,
    output logic [ADDER_WIDTH-1:0] add_in1,
    output logic [ADDER_WIDTH-1:0] add_in2,
    output logic                   add_cin,
    output logic                   add_K,
    input  logic [ADDER_WIDTH-1:0] add_sum,
    input  logic                   add_cout,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ADDER_WIDTH-1:0] resp_sum,
    output logic                   resp_cout,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load_val(LAT);

    ctrl_state_e            state_q, state_d;
    logic [ADDER_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic                   cin_q, cin_d;
    logic                   k_q, k_d;
    logic                   pend_q, pend_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [ADDER_WIDTH-1:0] sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lat_load_s, lat_en_s, lat_done_s;

    sift_out_lat_cnt #(
        .W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lat_load_s),
        .load_val_i (LAT_LOAD),
        .en_i       (lat_en_s),
        .done_o     (lat_done_s)
    );

    // Next-state and registered-output computation for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        cin_d        = cin_q;
        k_d          = k_q;
        // reinit is sticky in every state; it is consumed only at an accept.
        pend_d       = pend_q | reinit;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        cnt_d        = cnt_q;
        lat_load_s   = 1'b0;
        lat_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    in1_d       = req_a;
                    in2_d       = req_b;
                    cin_d       = req_cin;
                    // A reinit arriving on the accept cycle applies to this op.
                    k_d         = pend_q | reinit;
                    pend_d      = 1'b0;
                    lat_load_s  = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                lat_en_s = 1'b1;
                if (lat_done_s) begin
                    sum_d        = add_sum;
                    cout_d       = add_cout;
                    resp_valid_d = 1'b1;
                    // Once an operation has completed, later ones run with K=0.
                    k_d          = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any operation and restores K=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in1_q        <= {ADDER_WIDTH{1'b0}};
            in2_q        <= {ADDER_WIDTH{1'b0}};
            cin_q        <= 1'b0;
            k_q          <= 1'b1;
            pend_q       <= 1'b1;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            sum_q        <= {ADDER_WIDTH{1'b0}};
            cout_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            cin_q        <= cin_d;
            k_q          <= k_d;
            pend_q       <= pend_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign add_in1    = in1_q;
    assign add_in2    = in2_q;
    assign add_cin    = cin_q;
    assign add_K      = k_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign busy       = busy_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_sift_out_adder_ctrl.sv
// Self-checking bench for sift_out_adder_ctrl with a behavioural LAT=2 adder.
module tb_sift_out_adder_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_cin = 1'b0;
    logic        reinit = 1'b0;
    logic        resp_ready = 1'b0;

    logic        req_ready, add_cin, add_K, resp_valid, resp_cout, busy;
    logic [31:0] add_in1, add_in2, add_sum, resp_sum;
    logic        add_cout;
    logic [15:0] op_count;

    // Second instance with a narrow counter to exercise wrap-around.
    logic        req_ready2, add_cin2, add_K2, resp_valid2, resp_cout2, busy2;
    logic [31:0] add_in1_2, add_in2_2, resp_sum2;
    logic [3:0]  op_count2;

    // Behavioural adder: result valid LAT cycles after operands are applied.
    logic [32:0] s1 = 33'd0;
    logic [32:0] s2 = 33'd0;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_pend;
    int   exp_count;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= {1'b0, add_in1} + {1'b0, add_in2} + {32'd0, add_cin};
        s2 <= s1;
    end
    assign add_sum  = s2[31:0];
    assign add_cout = s2[32];

    sift_out_adder_ctrl #(.ADDER_WIDTH(32), .LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .reinit(reinit),
        .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin), .add_K(add_K),
        .add_sum(add_sum), .add_cout(add_cout), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
        .busy(busy), .op_count(op_count)
    );

    sift_out_adder_ctrl #(.ADDER_WIDTH(32), .LAT(LAT), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .reinit(reinit),
        .add_in1(add_in1_2), .add_in2(add_in2_2), .add_cin(add_cin2), .add_K(add_K2),
        .add_sum(add_sum), .add_cout(add_cout), .resp_valid(resp_valid2),
        .resp_ready(resp_ready), .resp_sum(resp_sum2), .resp_cout(resp_cout2),
        .busy(busy2), .op_count(op_count2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete operation: accept, settle, optional backpressure, handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic r_acc, input logic r_wait, input int hold,
                          input logic hold_req);
        logic [32:0] full;
        logic        exp_k;
        logic [31:0] first_sum;
        int          cyc;
        full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("req_ready_idle", {63'd0, req_ready}, 64'd1);
        check_val("busy_idle", {63'd0, busy}, 64'd0);
        req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; reinit = r_acc;
        exp_k = exp_pend | r_acc;
        exp_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reinit = r_wait;
        if (r_wait) exp_pend = 1'b1;
        check_val("add_K_issue", {63'd0, add_K}, {63'd0, exp_k});
        check_val("add_in1", {32'd0, add_in1}, {32'd0, a});
        check_val("add_in2", {32'd0, add_in2}, {32'd0, b});
        check_val("add_cin", {63'd0, add_cin}, {63'd0, cin});
        check_val("req_ready_busy", {63'd0, req_ready}, 64'd0);
        check_val("busy_wait", {63'd0, busy}, 64'd1);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            reinit = 1'b0;
            if (!resp_valid) check_val("add_K_stable", {63'd0, add_K}, {63'd0, exp_k});
        end
        check_val("latency", 64'(cyc), 64'(LAT + 1));
        check_val("resp_sum", {32'd0, resp_sum}, {32'd0, full[31:0]});
        check_val("resp_cout", {63'd0, resp_cout}, {63'd0, full[32]});
        check_val("add_K_after", {63'd0, add_K}, 64'd0);
        first_sum = resp_sum;
        for (int i = 0; i < hold; i++) begin
            req_valid = hold_req;
            req_a = ~a;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", {63'd0, resp_valid}, 64'd1);
            check_val("hold_sum", {32'd0, resp_sum}, {32'd0, first_sum});
            check_val("hold_ready", {63'd0, req_ready}, 64'd0);
            check_val("hold_in1", {32'd0, add_in1}, {32'd0, a});
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        exp_count++;
        check_val("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
        check_val("op_count", {48'd0, op_count}, 64'(exp_count % 65536));
        check_val("op_count_w4", {60'd0, op_count2}, 64'(exp_count % 16));
        check_val("req_ready_back", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        exp_pend  = 1'b1;
        exp_count = 0;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_val("rst_add_K", {63'd0, add_K}, 64'd1);
        check_val("rst_op_count", {48'd0, op_count}, 64'd0);
        check_val("rst_resp_sum", {32'd0, resp_sum}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_add_K", {63'd0, add_K}, 64'd1);

        // First op after reset runs with K=1, K drops after capture.
        run_op(32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Overflow into cout.
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Backpressure for 10 cycles with a competing request held high.
        run_op(32'h1234_5678, 32'h0101_0101, 1'b1, 1'b0, 1'b0, 10, 1'b1);
        // reinit during WAIT leaves this op at K=0 and arms the next one.
        run_op(32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op(32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        // reinit coincident with accept.
        run_op(32'd10, 32'd20, 1'b0, 1'b1, 1'b0, 1, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        req_valid = 1'b1; req_a = 32'd9; req_b = 32'd9; req_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_val("arst_add_K", {63'd0, add_K}, 64'd1);
        check_val("arst_op_count", {48'd0, op_count}, 64'd0);
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_req_ready", {63'd0, req_ready}, 64'd1);
        exp_pend  = 1'b1;
        exp_count = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized operations; enough to wrap the 4-bit counter.
        for (int n = 0; n < 36; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
